// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, write port, reserve port,
// scoreboard and status. The master drives operations; the slave is the
// register file itself.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                         READY;
  logic                         READ;
  logic [NUM_RD*ADDR_WIDTH-1:0] ADDR_R;
  logic [NUM_RD*DATA_WIDTH-1:0] DATA_R;
  logic                         RD_VALID;
  logic [NUM_RD-1:0]            RD_BUSY;
  logic                         WRITE;
  logic [ADDR_WIDTH-1:0]        ADDR_W;
  logic [DATA_WIDTH-1:0]        DATA_W;
  logic                         RSV;
  logic [ADDR_WIDTH-1:0]        ADDR_RSV;
  logic [DEPTH-1:0]             BUSY;

  modport master (
    output READ, ADDR_R, WRITE, ADDR_W, DATA_W, RSV, ADDR_RSV,
    input  READY, DATA_R, RD_VALID, RD_BUSY, BUSY
  );

  modport slave (
    input  READ, ADDR_R, WRITE, ADDR_W, DATA_W, RSV, ADDR_RSV,
    output READY, DATA_R, RD_VALID, RD_BUSY, BUSY
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered read data, write-to-read
// bypass, optional hard-wired zero register and a per-register busy
// scoreboard. After reset a sweep clears every entry so the storage can be
// a plain RAM without a reset net; READY rises when the sweep finishes.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic          CLK,
  input logic          RST,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]        mem_wdata;
  logic [NUM_RD*DATA_WIDTH-1:0] data_r_q, data_r_d;
  logic                         rd_valid_q, rd_valid_d;
  logic [NUM_RD-1:0]            rd_busy_q, rd_busy_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  logic                         running;
  logic                         wr_ok;
  logic                         rsv_ok;
  logic [ADDR_WIDTH-1:0]        port_addr [NUM_RD];
  logic [DATA_WIDTH-1:0]        port_data [NUM_RD];
  logic                         port_busy [NUM_RD];

  assign running = (state_q == RUN);
  // Writes/reserves to register 0 are dropped when it is hard-wired zero.
  assign wr_ok  = running && bus.WRITE && !(ZERO_REG && (bus.ADDR_W == '0));
  assign rsv_ok = running && bus.RSV && !(ZERO_REG && (bus.ADDR_RSV == '0));

  // Per-port read value: zero register, then same-cycle write bypass, then array.
  // Busy seen by the read is after the same-cycle write clear, before the reserve.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic hit;
      assign port_addr[gi] = bus.ADDR_R[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit           = wr_ok && (bus.ADDR_W == port_addr[gi]);
      assign port_data[gi] = (ZERO_REG && (port_addr[gi] == '0)) ? '0 :
                             hit ? bus.DATA_W : mem_q[port_addr[gi]];
      assign port_busy[gi] = hit ? 1'b0 : busy_q[port_addr[gi]];
    end
  endgenerate

  // Sweep FSM next state and the single array write port selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.ADDR_W;
    mem_wdata = bus.DATA_W;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        mem_we = wr_ok;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Read capture and scoreboard update; read data holds when READ is low.
  always_comb begin
    data_r_d   = data_r_q;
    rd_busy_d  = rd_busy_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    if (running) begin
      if (bus.READ) begin
        rd_valid_d = 1'b1;
        for (int k = 0; k < NUM_RD; k++) begin
          data_r_d[k*DATA_WIDTH +: DATA_WIDTH] = port_data[k];
          rd_busy_d[k]                         = port_busy[k];
        end
      end
      // Clear first, then set, so a new producer wins over a completing one.
      if (wr_ok)  busy_d[bus.ADDR_W]   = 1'b0;
      if (rsv_ok) busy_d[bus.ADDR_RSV] = 1'b1;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      data_r_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_busy_q  <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_r_q   <= data_r_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array without reset; contents are initialised by the sweep.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.READY    = running;
  assign bus.DATA_R   = data_r_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.RD_BUSY  = rd_busy_q;
  assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios followed by
// random traffic, compared against an array-based reference model.
module tb_reg_file_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  reg_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1'b1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic [DW-1:0]    e_data [NR];
  logic [NR-1:0]    e_rb;
  logic             e_valid;
  logic             m_ready;
  int               m_sweep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready", 64'(bus.READY), 64'(m_ready));
    chk("rd_valid", 64'(bus.RD_VALID), 64'(e_valid));
    for (int k = 0; k < NR; k++)
      chk($sformatf("data_r[%0d]", k), 64'(bus.DATA_R[k*DW +: DW]), 64'(e_data[k]));
    chk("rd_busy", 64'(bus.RD_BUSY), 64'(e_rb));
    chk("busy", 64'(bus.BUSY), 64'(m_busy));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < NR; k++) e_data[k] = '0;
    m_busy  = '0;
    e_rb    = '0;
    e_valid = 1'b0;
    m_ready = 1'b0;
    m_sweep = 0;
  endtask

  // Hold RST for 'hold' edges with random (ignored) traffic on the bus.
  task automatic do_reset(input int hold);
    for (int i = 0; i < hold; i++) begin
      rst          = 1'b1;
      bus.READ     = 1'b1;
      bus.ADDR_R   = NR*AW'($urandom);
      bus.WRITE    = 1'($urandom);
      bus.ADDR_W   = AW'($urandom);
      bus.DATA_W   = $urandom;
      bus.RSV      = 1'($urandom);
      bus.ADDR_RSV = AW'($urandom);
      @(posedge clk);
      #1;
      model_reset();
      check_outputs();
    end
    rst = 1'b0;
  endtask

  // One clock of stimulus: predict from the model, apply, then check.
  task automatic step(input logic rd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic wr, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                      input logic rsv, input logic [AW-1:0] arsv);
    logic          wr_ok;
    logic [AW-1:0] a;
    bus.READ     = rd;
    bus.ADDR_R   = {a1, a0};
    bus.WRITE    = wr;
    bus.ADDR_W   = aw;
    bus.DATA_W   = dw;
    bus.RSV      = rsv;
    bus.ADDR_RSV = arsv;
    if (m_ready) begin
      wr_ok = wr && (aw != 0);
      e_valid = rd;
      if (rd) begin
        for (int k = 0; k < NR; k++) begin
          a = (k == 0) ? a0 : a1;
          if (a == 0)                     e_data[k] = '0;
          else if (wr_ok && aw == a)      e_data[k] = dw;
          else                            e_data[k] = m_mem[a];
          e_rb[k] = (wr_ok && aw == a) ? 1'b0 : m_busy[a];
        end
      end
      if (wr_ok) begin
        m_mem[aw]  = dw;
        m_busy[aw] = 1'b0;
      end
      if (rsv && arsv != 0) m_busy[arsv] = 1'b1;
    end else begin
      e_valid = 1'b0;
      m_sweep++;
      if (m_sweep == DEPTH) m_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic rand_step();
    logic [AW-1:0] hi;
    hi = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1) : AW'(7);
    step(1'($urandom), AW'($urandom_range(0, int'(hi))), AW'($urandom_range(0, int'(hi))),
         1'($urandom), AW'($urandom_range(0, int'(hi))), $urandom,
         1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, int'(hi))));
  endtask

  initial begin
    rst          = 1'b0;
    bus.READ     = 1'b0;
    bus.ADDR_R   = '0;
    bus.WRITE    = 1'b0;
    bus.ADDR_W   = '0;
    bus.DATA_W   = '0;
    bus.RSV      = 1'b0;
    bus.ADDR_RSV = '0;
    model_reset();

    // Reset, then sweep with a write/reserve to r9 that must be ignored
    do_reset(1);
    step(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9);
    for (int i = 1; i < DEPTH; i++) rand_step();
    $display("sweep done ready=%0b", bus.READY);

    // Every register reads back as zero
    for (int a = 0; a < DEPTH; a += 2)
      step(1'b1, AW'(a), AW'(a + 1), 1'b0, '0, '0, 1'b0, '0);

    // Write then read on both ports, then a hold cycle
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0);
    step(1'b1, 5'd5, 5'd5, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 5'd1, 5'd2, 1'b0, '0, '0, 1'b0, '0);
    $display("write/read r5 data=%h", bus.DATA_R);

    // Bypass on port 0, zero register on port 1
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    step(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, '0);
    $display("bypass/zero data=%h", bus.DATA_R);

    // Scoreboard: reserve, read busy, completing write, reserve+write race
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
    step(1'b1, 5'd3, 5'd4, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'hA5, 1'b0, '0);
    step(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h5A, 1'b1, 5'd3);
    step(1'b1, 5'd3, 5'd0, 1'b0, '0, '0, 1'b0, '0);
    $display("scoreboard busy=%h rd_busy=%b", bus.BUSY, bus.RD_BUSY);

    // Random traffic
    for (int i = 0; i < 400; i++) rand_step();
    $display("random phase 1 done checks=%0d", checks);

    // Reset during RUN with a read in flight, abort mid-sweep, held reset
    do_reset(1);
    for (int i = 0; i < 10; i++) rand_step();
    do_reset(3);
    for (int i = 0; i < DEPTH; i++) rand_step();
    $display("re-sweep done ready=%0b", bus.READY);
    for (int i = 0; i < 300; i++) rand_step();
    $display("random phase 2 done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with registered read data, write-to-read bypass, optional hard-wired zero register and per-register busy scoreboard. Successor to the fixed 32x32 dual-read register file for the CPU datapath. After reset the array is cleared by a sweep state machine, so the storage can map onto RAM, and READY reports completion. The decode stage uses the scoreboard to detect operands still pending from in-flight producers.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reserves

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- READY  out  1  1 = clear sweep done, block accepts operations
- READ  in  1  read strobe for all ports
- ADDR_R  in  NUM_RD*ADDR_WIDTH  read addresses; port k = slice k
- DATA_R  out  NUM_RD*DATA_WIDTH  registered read data; port k = slice k
- RD_VALID  out  1  DATA_R/RD_BUSY updated by a read on the previous edge
- RD_BUSY  out  NUM_RD  per-port: addressed register was pending at read time
- WRITE  in  1  write strobe
- ADDR_W  in  ADDR_WIDTH  write address
- DATA_W  in  DATA_WIDTH  write data
- RSV  in  1  reserve strobe; marks ADDR_RSV pending
- ADDR_RSV  in  ADDR_WIDTH  register to reserve
- BUSY  out  DEPTH  scoreboard bit per register

## Operation
- FSM states: CLEAR, RUN.
- RST=1 at an edge: state goes to CLEAR and the sweep counter goes to 0. DATA_R, RD_VALID, RD_BUSY, READY and BUSY are all cleared to 0.
- CLEAR:
  - Each cycle writes 0 to register[counter], then increments the counter.
  - After writing DEPTH-1, state goes to RUN and READY becomes 1 on that same edge.
  - READ, WRITE and RSV are ignored. RD_VALID stays 0.
- RUN, write: WRITE=1 stores DATA_W at ADDR_W. With ZERO_REG=1, writes to address 0 are dropped.
- RUN, read: READ=1 captures every port k into DATA_R slice k. RD_VALID=1 on the following cycle.
  - Bypass: if WRITE=1 to the same address in the same cycle (and not a dropped zero-register write), port k returns DATA_W.
  - ZERO_REG=1 with address 0 returns 0.
  - Multiple ports may address the same register; each returns the same value.
- READ=0: DATA_R and RD_BUSY hold their previous values, RD_VALID=0.
- Scoreboard:
  - RSV=1 sets BUSY[ADDR_RSV].
  - A performed WRITE clears BUSY[ADDR_W].
  - RSV and WRITE to the same address in the same cycle: BUSY ends 1 (the new producer wins).
  - With ZERO_REG=1, BUSY[0] is constant 0.
- RD_BUSY[k]: the busy bit of the port-k address after the same-cycle write clear and before the same-cycle reserve set. A read that coincides with the completing write sees RD_BUSY=0 and the bypassed data.

## Timing
- Read latency is 1 cycle: address and READ presented at edge n give DATA_R/RD_BUSY/RD_VALID valid after edge n.
- A write at edge n is visible to reads sampled at edge n (bypass) and later.
- BUSY updates at the edge where RSV/WRITE are sampled.
- Reset to ready takes DEPTH+1 edges: the RST edge plus DEPTH sweep edges. For DEPTH=32, READY=1 after the 33rd edge counted from the edge where RST=1.
- RST=1 held for multiple cycles keeps the counter at 0. A sweep starts on the first edge with RST=0.
- RST mid-sweep restarts the sweep from 0.
- RST during RUN aborts any read: RD_VALID=0 next cycle and array contents are re-cleared.
- The counter is ADDR_WIDTH bits. It does not wrap: RUN is entered when counter = DEPTH-1 is written.

## Test plan
- Reset sweep: pulse RST, DEPTH=32 -> READY=0 for 32 cycles then 1; all BUSY=0; a read of every address returns 0.
- Write/read: write 0xDEADBEEF to r5, next cycle READ with ADDR_R={r5,r5} -> both DATA_R slices 0xDEADBEEF, RD_VALID=1 one cycle later.
- Bypass and zero register: in the same cycle WRITE r7=0x12345678 and READ ports {r7,r0}, after writing 0xFFFFFFFF to r0 earlier -> DATA_R = {0x12345678, 0x00000000}.
- Scoreboard: RSV r3, then READ r3 -> RD_BUSY[0]=1. WRITE r3=0xA5 with a simultaneous READ r3 -> RD_BUSY=0, data 0xA5, BUSY[3]=0. RSV and WRITE r3 together -> BUSY[3]=1.
- Ignore-while-clearing: WRITE r9=0x55 and RSV r9 during CLEAR -> after READY, r9 reads 0 and BUSY[9]=0.
- Reset mid-sweep and hold: RST at sweep cycle 10 -> READY rises 32 cycles after RST drops. READ=0 cycles -> DATA_R holds, RD_VALID=0.
